// File: rtl/lsu_subword_ctrl.sv
// Load/store controller adding RV32I byte/halfword access on a word-wide async-read memory.
// Latency: loads, SW and rejected ops are combinational; SB/SH take 2 cycles (read, then write).
// Backpressure: stall is high in the read cycle of SB/SH. Macro LSU_MISALIGN_TRAP_EN enables the fault trap.
module lsu_subword_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] addr_q, addr_d;

  logic        is_byte, is_half, is_word;
  logic        legal_ld, legal_st, legal;
  logic        blocked, op_go;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data, merge_word;
  logic        rd_c, wr_c, st_c;
  logic [31:0] ld_c, addr_c, wdata_c;

  assign is_byte  = (req_funct3[1:0] == 2'b00);
  assign is_half  = (req_funct3[1:0] == 2'b01);
  assign is_word  = (req_funct3[1:0] == 2'b10);
  // Loads: 000,001,010,100,101. Stores: 000,001,010.
  assign legal_ld = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
  assign legal_st = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
  assign legal    = req_write ? legal_st : legal_ld;

`ifdef LSU_MISALIGN_TRAP_EN
  logic        misal, fault_evt;
  logic        fault_valid_q, fault_valid_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  assign misal     = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign blocked   = misal;
  assign fault_evt = (state_q == IDLE) && req_valid && legal && misal;

  // A new fault latches when the flag is free or being cleared in the same cycle.
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    if (fault_evt && (!fault_valid_q || fault_clr)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = req_addr;
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
    end
  end

  // Fault flag and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= 32'h0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
`else
  logic unused_fault_clr;

  // Misaligned accesses simply use the aligned-down lanes.
  assign blocked          = 1'b0;
  assign fault_valid      = 1'b0;
  assign fault_addr       = 32'h0;
  assign unused_fault_clr = fault_clr;
`endif

  assign op_go    = req_valid && legal && !blocked;
  assign byte_sel = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
  assign half_sel = mem_rdata[{req_addr[1], 4'b0000} +: 16];

  // Lane select and sign/zero extension of the load result.
  always_comb begin
    ext_data = 32'h0;
    case (req_funct3)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  ext_data = mem_rdata;
      3'b100:  ext_data = {24'h0, byte_sel};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = 32'h0;
    endcase
  end

  // Current word with the store's byte or halfword lanes replaced.
  always_comb begin
    merge_word = mem_rdata;
    if (is_half) begin
      merge_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end else if (is_byte) begin
      merge_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end
  end

  // Next state, RMW capture and memory/pipeline strobes.
  always_comb begin
    state_d = state_q;
    merge_d = merge_q;
    addr_d  = addr_q;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    st_c    = 1'b0;
    ld_c    = 32'h0;
    addr_c  = {req_addr[31:2], 2'b00};
    wdata_c = req_wdata;
    case (state_q)
      IDLE: begin
        if (op_go) begin
          if (!req_write) begin
            rd_c = 1'b1;
            ld_c = ext_data;
          end else if (is_word) begin
            wr_c = 1'b1;
          end else begin
            rd_c    = 1'b1;
            st_c    = 1'b1;
            merge_d = merge_word;
            addr_d  = {req_addr[31:2], 2'b00};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // Request inputs still show the same store; only the captured word matters.
        wr_c    = 1'b1;
        addr_c  = addr_q;
        wdata_c = merge_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RMW merge word and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_q <= 32'h0;
      addr_q  <= 32'h0;
    end else begin
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end

  // Strobes and load result are held quiet while reset is asserted.
  assign mem_read  = rd_c & rst_n;
  assign mem_write = wr_c & rst_n;
  assign stall     = st_c & rst_n;
  assign load_data = rst_n ? ld_c : 32'h0;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;

endmodule
